spin_speed_ramp_selector: RTL
=============================

// Module: spin_speed_ramp_selector
// PURPOSE
//  Parametrised spin-speed selector with a motor ramp generator. Holds the user's spin level,
//  loads per-mode default and ceiling levels, steps the level on inc/dec button edges, and ramps
//  motor_speed toward the selected speed. Sits between the front-panel buttons and the drum-motor driver.
// PARAMETERS
//  NUM_LEVELS  4     number of spin levels (index 0..NUM_LEVELS-1)
//  SPEED_W     11    width of speed values, rpm
//  SPEED_MIN   400   speed of level 0
//  SPEED_STEP  400   rpm added per level
//  SPEED_MAX   1400  hard rpm ceiling; level speed = min(SPEED_MIN+i*SPEED_STEP, SPEED_MAX)
//  WRAP        1     1: inc/dec wrap at the limits; 0: saturate at the limits and pulse limit_hit
//  RAMP_STEP   50    rpm change per ramp tick
//  RAMP_DIV    16    clk cycles per ramp tick, >=1
// PORTS
//  clk         in   1        system clock, rising edge
//  reset_n     in   1        asynchronous active-low reset
//  wash_mode   in   3        wash mode code, sampled only on load
//  load        in   1        level-sensitive; load mode default level and ceiling
//  inc         in   1        level button, acted on at its rising edge
//  dec         in   1        level button, acted on at its rising edge
//  lock        in   1        1 = cycle running; inc/dec are ignored (edge registers still track)
//  spin_en     in   1        request motor spin at the selected speed
//  sel_index   out  IDX_W    current level, IDX_W = $clog2(NUM_LEVELS)
//  sel_speed   out  SPEED_W  rpm of sel_index (combinational from sel_index)
//  motor_speed out  SPEED_W  ramped speed command to the motor driver
//  at_speed    out  1        registered; spin_en && motor_speed==sel_speed
//  limit_hit   out  1        one-cycle pulse when a saturating inc/dec is blocked (WRAP=0 only)
// BEHAVIOUR
//  Reset: sel_index=0, mode_q=0, max_q=NUM_LEVELS-1, edge registers=0, motor_speed=0,
//   at_speed=0, limit_hit=0, ramp FSM=IDLE, tick counter=0.
//  Edges: inc_e = inc & ~inc_q (same for dec). inc_q and dec_q update every cycle, including under lock.
//  Level update priority per cycle: load > lock > (inc_e & dec_e: no change) > inc_e > dec_e.
//  load: mode_q<=wash_mode; max_q<=MAX_LVL[wash_mode]; sel_index<=min(DEF_LVL, MAX_LVL).
//  inc_e at max_q: WRAP=1 -> 0; WRAP=0 -> hold, limit_hit=1 next cycle. Otherwise +1.
//  dec_e at 0: WRAP=1 -> max_q; WRAP=0 -> hold, limit_hit=1. Otherwise -1.
//  Latency: edge sampled at clk n -> sel_index/sel_speed updated after clk n.
//  Mode table (mode: default/max): 0 cotton 3/3, 1 synth 3/3, 2 drum 2/3, 3 quick 1/3,
//   4 daily 3/3, 5 delicates 0/1, 6 wool 1/1, 7 colours 3/3; indices clamped to NUM_LEVELS-1.
//  Ramp target T = spin_en ? sel_speed : 0. FSM states:
//   IDLE: motor_speed==0 and !spin_en; tick counter held at 0. spin_en -> RAMP_UP.
//   RAMP_UP / RAMP_DOWN: every RAMP_DIV cycles, step toward T by RAMP_STEP, clamped to land exactly on T.
//   HOLD: motor_speed==T; counter held. Any change of T re-enters RAMP_UP or RAMP_DOWN.
//   When T==0 and motor_speed reaches 0 -> IDLE.
//  First step occurs RAMP_DIV cycles after entering RAMP_* from IDLE or HOLD.
//  Target changes mid-ramp (level edit, spin_en drop) redirect immediately; no overshoot,
//   and the counter is not reset.
//  Widths: all speed arithmetic is SPEED_W+1 bits internally, so no wrap near 2^SPEED_W.
//  Reset asserted mid-ramp: motor_speed forced to 0 asynchronously (driver-side braking owns safety).
// STRUCTURE
//  Package spin_pkg: wash-mode codes, DEF_LVL/MAX_LVL tables, function lvl_to_rpm(), ramp state enum.
//  Sub-module spin_ramp_gen (ramp FSM, tick counter, motor_speed, at_speed): inputs target, spin_en.
//  Top module: edge detect, level register, mode capture, lvl->rpm mapping, limit_hit.
// TESTING
//  1 Reset, load with wash_mode=5 -> sel_index=0, sel_speed=400; three inc edges -> 800,400,800 (max=1).
//  2 WRAP=0, mode 0 loaded (1400): inc edge -> index holds at 3, limit_hit high exactly 1 cycle.
//  3 inc and dec rise in the same cycle -> no change; inc held high 10 cycles -> exactly one step;
//    lock=1 during an inc edge -> ignored, and no step after lock drops while inc stays high.
//  4 Mode 3 (800), spin_en=1, RAMP_DIV=4 -> motor_speed +50 every 4 clks, 16 steps to 800,
//    at_speed rises the cycle after 800 is reached.
//  5 At 800 spin_en drops -> ramps down to 0 and FSM reaches IDLE; inc edge mid-ramp-up
//    (800->1200 target) -> ramp continues to 1200 with no stall.
//  6 reset_n pulsed low mid-ramp between clock edges -> all outputs equal reset values immediately.

Source files
------------

// File: rtl/spin_pkg.sv
// Shared types and tables for the spin-speed selector: wash-mode codes, per-mode
// default/ceiling levels, level-to-rpm mapping and the ramp FSM state encoding.
package spin_pkg;

   typedef enum logic [2:0] {
      ModeCotton     = 3'd0,
      ModeSynth      = 3'd1,
      ModeDrum       = 3'd2,
      ModeQuick      = 3'd3,
      ModeDaily      = 3'd4,
      ModeDelicates  = 3'd5,
      ModeWool       = 3'd6,
      ModeColours    = 3'd7
   } wash_mode_e;

   typedef enum logic [1:0] {
      StIdle,
      StRampUp,
      StRampDown,
      StHold
   } ramp_state_e;

   localparam int unsigned NUM_MODES = 8;

   // Indexed by wash_mode; callers clamp to their own NUM_LEVELS-1.
   localparam int unsigned DEF_LVL [NUM_MODES] = '{3, 3, 2, 1, 3, 0, 1, 3};
   localparam int unsigned MAX_LVL [NUM_MODES] = '{3, 3, 3, 3, 3, 1, 1, 3};

   function automatic int unsigned lvl_to_rpm(input int unsigned lvl,
                                              input int unsigned spd_min,
                                              input int unsigned spd_step,
                                              input int unsigned spd_max);
      int unsigned rpm;
      rpm = spd_min + lvl * spd_step;
      return (rpm > spd_max) ? spd_max : rpm;
   endfunction

endpackage

// File: rtl/spin_ramp_gen.sv
// Motor ramp generator: slews motor_speed toward target in RAMP_STEP increments,
// one step every RAMP_DIV clocks, and flags at_speed once the target is held.
module spin_ramp_gen
   import spin_pkg::*;
#(
   parameter int unsigned SPEED_W   = 11,
   parameter int unsigned RAMP_STEP = 50,
   parameter int unsigned RAMP_DIV  = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [SPEED_W-1:0] target,
   input  logic               spin_en,
   output logic [SPEED_W-1:0] motor_speed,
   output logic               at_speed
);

   localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned EXT_W = SPEED_W + 1;
   localparam logic [EXT_W-1:0] STEP_X = EXT_W'(RAMP_STEP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

   ramp_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic               at_speed_q;

   logic [EXT_W-1:0]   speed_x, target_x, step_x, next_x;
   logic               tick;

   // One extra bit keeps speed +/- step from wrapping near 2^SPEED_W.
   assign speed_x  = {1'b0, speed_q};
   assign target_x = {1'b0, target};
   assign tick     = (cnt_q == CNT_LAST);

   always_comb begin
      step_x = speed_x;
      if (speed_x < target_x) begin
         step_x = ((target_x - speed_x) > STEP_X) ? (speed_x + STEP_X) : target_x;
      end else if (speed_x > target_x) begin
         step_x = ((speed_x - target_x) > STEP_X) ? (speed_x - STEP_X) : target_x;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      speed_d = speed_q;
      next_x  = speed_x;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (spin_en) state_d = StRampUp;
         end
         StHold: begin
            cnt_d = '0;
            if (speed_x < target_x) begin
               state_d = StRampUp;
            end else if (speed_x > target_x) begin
               state_d = StRampDown;
            end else if (target_x == '0 && !spin_en) begin
               state_d = StIdle;
            end
         end
         StRampUp, StRampDown: begin
            // The divider keeps running across redirects so a target change never stalls.
            if (tick) begin
               next_x  = step_x;
               speed_d = step_x[SPEED_W-1:0];
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (next_x == target_x) begin
               cnt_d   = '0;
               state_d = (target_x == '0 && !spin_en) ? StIdle : StHold;
            end else begin
               state_d = (next_x < target_x) ? StRampUp : StRampDown;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         speed_q    <= '0;
         at_speed_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         speed_q    <= speed_d;
         at_speed_q <= spin_en && (speed_q == target);
      end
   end

   assign motor_speed = speed_q;
   assign at_speed    = at_speed_q;

endmodule

// File: rtl/spin_speed_ramp_selector.sv
// Front-panel spin-speed selector: level register driven by inc/dec edges and mode
// loads, mapped to rpm and fed to the motor ramp generator.
module spin_speed_ramp_selector
   import spin_pkg::*;
#(
   parameter int unsigned NUM_LEVELS = 4,
   parameter int unsigned SPEED_W    = 11,
   parameter int unsigned SPEED_MIN  = 400,
   parameter int unsigned SPEED_STEP = 400,
   parameter int unsigned SPEED_MAX  = 1400,
   parameter bit          WRAP       = 1'b1,
   parameter int unsigned RAMP_STEP  = 50,
   parameter int unsigned RAMP_DIV   = 16,
   localparam int unsigned IDX_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [2:0]         wash_mode,
   input  logic               load,
   input  logic               inc,
   input  logic               dec,
   input  logic               lock,
   input  logic               spin_en,
   output logic [IDX_W-1:0]   sel_index,
   output logic [SPEED_W-1:0] sel_speed,
   output logic [SPEED_W-1:0] motor_speed,
   output logic               at_speed,
   output logic               limit_hit
);

   localparam int unsigned LAST = NUM_LEVELS - 1;

   logic             inc_q, dec_q, inc_e, dec_e;
   wash_mode_e       mode_q;
   logic             mode_valid_q;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic [IDX_W-1:0] max_lvl, load_max, load_def;
   logic             limit_q, limit_d;
   logic [SPEED_W-1:0] target;

   function automatic logic [IDX_W-1:0] clamp_idx(input int unsigned lvl);
      return IDX_W'((lvl > LAST) ? LAST : lvl);
   endfunction

   assign inc_e = inc & ~inc_q;
   assign dec_e = dec & ~dec_q;

   // Until the first load the ceiling is the top level, not mode 0's table entry.
   assign max_lvl  = mode_valid_q ? clamp_idx(MAX_LVL[mode_q]) : clamp_idx(LAST);
   assign load_max = clamp_idx(MAX_LVL[wash_mode]);
   assign load_def = clamp_idx(DEF_LVL[wash_mode]);

   always_comb begin
      sel_d   = sel_q;
      limit_d = 1'b0;
      if (load) begin
         sel_d = (load_def < load_max) ? load_def : load_max;
      end else if (!lock && (inc_e ^ dec_e)) begin
         if (inc_e) begin
            if (sel_q >= max_lvl) begin
               if (WRAP) sel_d = '0;
               else      limit_d = 1'b1;
            end else begin
               sel_d = sel_q + IDX_W'(1);
            end
         end else begin
            if (sel_q == '0) begin
               if (WRAP) sel_d = max_lvl;
               else      limit_d = 1'b1;
            end else begin
               sel_d = sel_q - IDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inc_q        <= 1'b0;
         dec_q        <= 1'b0;
         mode_q       <= ModeCotton;
         mode_valid_q <= 1'b0;
         sel_q        <= '0;
         limit_q      <= 1'b0;
      end else begin
         inc_q   <= inc;
         dec_q   <= dec;
         sel_q   <= sel_d;
         limit_q <= limit_d;
         if (load) begin
            mode_q       <= wash_mode_e'(wash_mode);
            mode_valid_q <= 1'b1;
         end
      end
   end

   always_comb begin
      sel_speed = '0;
      for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
         if (sel_q == IDX_W'(i)) begin
            sel_speed = SPEED_W'(lvl_to_rpm(i, SPEED_MIN, SPEED_STEP, SPEED_MAX));
         end
      end
   end

   assign target = spin_en ? sel_speed : '0;

   spin_ramp_gen #(
      .SPEED_W   (SPEED_W),
      .RAMP_STEP (RAMP_STEP),
      .RAMP_DIV  (RAMP_DIV)
   ) u_ramp (
      .clk         (clk),
      .reset_n     (reset_n),
      .target      (target),
      .spin_en     (spin_en),
      .motor_speed (motor_speed),
      .at_speed    (at_speed)
   );

   assign sel_index = sel_q;
   assign limit_hit = limit_q;

endmodule
